// File: rtl/button_reader.sv
// Debounced button reader: input sync, per-bit debounce, press/release
// edge pulses and per-bit auto-repeat.
module button_reader #(
    parameter int               N_BTN     = 7,
    parameter int               DB_CNT    = 250000,
    parameter int               RPT_DELAY = 12500000,
    parameter int               RPT_RATE  = 2500000,
    parameter logic [N_BTN-1:0] INV_MASK  = 7'b0000001
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] o_state,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release,
    output logic [N_BTN-1:0] o_repeat,
    output logic             o_any
);

    localparam int MAX_AB = (DB_CNT > RPT_DELAY) ? DB_CNT : RPT_DELAY;
    localparam int MAX_C  = (MAX_AB > RPT_RATE) ? MAX_AB : RPT_RATE;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CNT - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'((RPT_DELAY > 0) ? RPT_DELAY - 1 : 0);
    localparam logic [CW-1:0] RT_LAST  = CW'(RPT_RATE - 1);
    localparam bit            RPT_EN   = (RPT_DELAY != 0);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_e;

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] state_q, state_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] repeat_q, repeat_d;
    logic [CW-1:0]    db_cnt_q [N_BTN];
    logic [CW-1:0]    db_cnt_d [N_BTN];
    logic [CW-1:0]    rpt_cnt_q [N_BTN];
    logic [CW-1:0]    rpt_cnt_d [N_BTN];
    rpt_state_e       fsm_q [N_BTN];
    rpt_state_e       fsm_d [N_BTN];

    // Next-state: synchroniser, debounce counters, edge pulses, repeat FSMs
    always_comb begin
        sync1_d   = btn ^ INV_MASK;
        sync2_d   = sync1_q;
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        repeat_d  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            db_cnt_d[i]  = '0;
            rpt_cnt_d[i] = '0;
            fsm_d[i]     = fsm_q[i];

            if (sync2_q[i] != state_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    state_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end

            press_d[i]   = state_d[i] & ~state_q[i];
            release_d[i] = ~state_d[i] & state_q[i];

            case (fsm_q[i])
                IDLE: begin
                    if (press_d[i] && RPT_EN) begin
                        fsm_d[i] = DELAY;
                    end
                end
                DELAY: begin
                    if (rpt_cnt_q[i] == DLY_LAST) begin
                        fsm_d[i]    = REPEAT;
                        repeat_d[i] = 1'b1;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rpt_cnt_q[i] == RT_LAST) begin
                        repeat_d[i] = 1'b1;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    fsm_d[i] = IDLE;
                end
            endcase

            // A release cancels any pending repeat in the same cycle
            if (release_d[i]) begin
                fsm_d[i]     = IDLE;
                rpt_cnt_d[i] = '0;
                repeat_d[i]  = 1'b0;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i]  <= '0;
                rpt_cnt_q[i] <= '0;
                fsm_q[i]     <= IDLE;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
                fsm_q[i]     <= fsm_d[i];
            end
        end
    end

    assign o_state   = state_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_repeat  = repeat_q;
    assign o_any     = |state_q;

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: directed scenarios then random pin activity,
// compared every cycle against a behavioural model.
module tb_button_reader;

    localparam int         N   = 7;
    localparam int         DB  = 4;
    localparam int         RD  = 10;
    localparam int         RR  = 3;
    localparam logic [6:0] INV = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] btn;
    logic [6:0] o_state, o_press, o_release, o_repeat;
    logic       o_any;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit [6:0] p1, p2, st, ep, er, erp;
    int run_len [N];
    int held [N];
    int npress [N];
    int nrel [N];
    int nrpt [N];

    button_reader #(
        .N_BTN(N), .DB_CNT(DB), .RPT_DELAY(RD),
        .RPT_RATE(RR), .INV_MASK(INV)
    ) dut (
        .i_clk(clk), .i_rst(rst), .btn(btn),
        .o_state(o_state), .o_press(o_press),
        .o_release(o_release), .o_repeat(o_repeat),
        .o_any(o_any)
    );

    always #5 clk = ~clk;

    // Reference: pin -> 2-cycle delay -> accept after DB differing samples;
    // repeats at RD cycles after press and every RR cycles after that.
    task automatic model();
        if (rst) begin
            p1 = '0; p2 = '0; st = '0;
            ep = '0; er = '0; erp = '0;
            for (int i = 0; i < N; i++) begin
                run_len[i] = 0;
                held[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                bit ns;
                ns = st[i];
                if (p2[i] != st[i]) begin
                    run_len[i]++;
                    if (run_len[i] == DB) begin
                        ns = p2[i];
                        run_len[i] = 0;
                    end
                end else begin
                    run_len[i] = 0;
                end
                ep[i] = ns & ~st[i];
                er[i] = ~ns & st[i];
                if (ep[i]) held[i] = 0;
                else if (ns) held[i]++;
                erp[i] = ns && !ep[i] && (RD > 0) && held[i] >= RD
                         && ((held[i] - RD) % RR == 0);
                st[i] = ns;
            end
            p2 = p1;
            p1 = btn ^ INV;
        end
    endtask

    task automatic chk(string tag, logic [6:0] got, logic [6:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            npress[i] = 0;
            nrel[i] = 0;
            nrpt[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model();
        #1;
        cyc++;
        chk("state", o_state, st);
        chk("press", o_press, ep);
        chk("release", o_release, er);
        chk("repeat", o_repeat, erp);
        chk("any", {6'b0, o_any}, {6'b0, |st});
        chk("press_and_repeat", o_press & o_repeat, 7'b0);
        for (int i = 0; i < N; i++) begin
            npress[i] += int'(o_press[i]);
            nrel[i]   += int'(o_release[i]);
            nrpt[i]   += int'(o_repeat[i]);
        end
    endtask

    task automatic run_n(int n);
        repeat (n) step();
    endtask

    initial begin
        rst = 1'b1;
        btn = 7'b0000001;
        clr();
        run_n(3);
        chk("reset_state", o_state, 7'b0);
        rst = 1'b0;

        // Active-low bit 0 idles high -> not pressed
        run_n(8);
        chk("idle_bit0", {6'b0, o_state[0]}, 7'd0);
        btn[0] = 1'b0;
        run_n(5);
        chk("bit0_no_early", {6'b0, o_press[0]}, 7'd0);
        run_n(1);
        chk("bit0_press_t6", {6'b0, o_press[0]}, 7'd1);
        btn[0] = 1'b1;
        run_n(10);

        // Held press: press at T+6, repeats at T+16, T+19, T+22
        clr();
        btn[1] = 1'b1;
        run_n(6);
        chk("b1_press_t6", {6'b0, o_press[1]}, 7'd1);
        run_n(10);
        chk("b1_rpt_t16", {6'b0, o_repeat[1]}, 7'd1);
        run_n(3);
        chk("b1_rpt_t19", {6'b0, o_repeat[1]}, 7'd1);
        run_n(3);
        chk("b1_rpt_t22", {6'b0, o_repeat[1]}, 7'd1);
        chk("b1_rpt_count", 7'(nrpt[1]), 7'd3);
        btn[1] = 1'b0;
        run_n(10);

        // Glitch of 3 cycles is rejected
        clr();
        btn[2] = 1'b1;
        run_n(3);
        btn[2] = 1'b0;
        run_n(10);
        chk("b2_glitch_press", 7'(npress[2]), 7'd0);

        // Press held 12 cycles of o_state: one press, repeat, release
        clr();
        btn[3] = 1'b1;
        run_n(12);
        btn[3] = 1'b0;
        run_n(6);
        chk("b3_release_p12", {6'b0, o_release[3]}, 7'd1);
        run_n(20);
        chk("b3_press_cnt", 7'(npress[3]), 7'd1);
        chk("b3_rpt_cnt", 7'(nrpt[3]), 7'd1);
        chk("b3_rel_cnt", 7'(nrel[3]), 7'd1);

        // Reset while held: no release, fresh press later
        clr();
        btn[4] = 1'b1;
        run_n(11);
        rst = 1'b1;
        run_n(1);
        chk("b4_rst_state", o_state, 7'b0);
        chk("b4_rst_any", {6'b0, o_any}, 7'd0);
        rst = 1'b0;
        run_n(5);
        chk("b4_no_early", {6'b0, o_press[4]}, 7'd0);
        run_n(1);
        chk("b4_repress", {6'b0, o_press[4]}, 7'd1);
        chk("b4_no_release", 7'(nrel[4]), 7'd0);
        btn[4] = 1'b0;
        run_n(10);

        // Simultaneous events on two bits
        btn[1] = 1'b1;
        btn[5] = 1'b1;
        run_n(6);
        chk("b15_press", o_press, 7'b0100010);
        chk("b15_any", {6'b0, o_any}, 7'd1);
        run_n(4);
        btn[1] = 1'b0;
        btn[5] = 1'b0;
        run_n(6);
        chk("b15_release", o_release, 7'b0100010);
        chk("b15_any_off", {6'b0, o_any}, 7'd0);
        run_n(4);

        // Random pin activity with occasional resets
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 7) == 0)
                btn[$urandom_range(0, 6)] ^= 1'b1;
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        run_n(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
